// File: rtl/sdram_burst_arbiter_if.sv
// Burst request/handshake bundle between the frame-buffer arbiter and the SDRAM controller.
interface sdram_burst_arbiter_if #(
  parameter int OFS_W = 20
);
  logic             sdram_wr_req;
  logic             sdram_rd_req;
  logic [OFS_W+1:0] sdram_addr;
  logic             burst_ack;
  logic             burst_done;

  modport master (
    output sdram_wr_req, sdram_rd_req, sdram_addr,
    input  burst_ack, burst_done
  );

  modport slave (
    input  sdram_wr_req, sdram_rd_req, sdram_addr,
    output burst_ack, burst_done
  );
endinterface

// File: rtl/sdram_burst_arbiter.sv
// One-burst-at-a-time scheduler between camera write FIFO and VGA read FIFO,
// walking per-port frame offsets within the ping-pong frame buffer banks.
module sdram_burst_arbiter #(
  parameter int BURST_LEN   = 256,
  parameter int FRAME_WORDS = 307200,
  parameter int OFS_W       = 20,
  parameter int USE_W       = 10,
  parameter int RD_URGENT   = 256,
  parameter int RD_THRESH   = 768
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sdram_init_done,
  input  logic [1:0]            wr_bank,
  input  logic [1:0]            rd_bank,
  input  logic                  wr_load,
  input  logic                  rd_load,
  input  logic [USE_W-1:0]      wrf_use,
  input  logic [USE_W-1:0]      rdf_use,
  sdram_burst_arbiter_if.master ctrl,
  output logic                  frame_write_done,
  output logic                  frame_read_done
);

  localparam logic [USE_W:0]   BURST_U  = (USE_W+1)'(BURST_LEN);
  localparam logic [USE_W:0]   URGENT_U = (USE_W+1)'(RD_URGENT);
  localparam logic [USE_W:0]   THRESH_U = (USE_W+1)'(RD_THRESH);
  localparam logic [OFS_W-1:0] OFS_STEP = OFS_W'(BURST_LEN);
  localparam logic [OFS_W-1:0] OFS_LAST = OFS_W'(FRAME_WORDS - BURST_LEN);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT} state_t;
  typedef enum logic {GNT_WR, GNT_RD} grant_t;

  state_t           state, state_n;
  grant_t           last_grant, last_grant_n;
  logic [OFS_W-1:0] wr_ofs, wr_ofs_n, rd_ofs, rd_ofs_n;
  logic             wr_pend, wr_pend_n, rd_pend, rd_pend_n;
  logic             wr_req_q, wr_req_n, rd_req_q, rd_req_n;
  logic [OFS_W+1:0] addr_q, addr_n;
  logic             fwd_n, frd_n;

  logic             wr_elig, rd_elig, rd_urgent, pick_rd, pick_wr;
  logic             wr_active, rd_active;
  logic [OFS_W-1:0] wr_ofs_cur, rd_ofs_cur;

  assign wr_elig   = sdram_init_done && ({1'b0, wrf_use} >= BURST_U);
  assign rd_elig   = sdram_init_done && ({1'b0, rdf_use} <  THRESH_U);
  assign rd_urgent = {1'b0, rdf_use} < URGENT_U;
  assign pick_rd   = rd_elig && (rd_urgent || !wr_elig || last_grant == GNT_WR);
  assign pick_wr   = wr_elig && !pick_rd;

  assign wr_active = (state == WR_REQ) || (state == WR_WAIT);
  assign rd_active = (state == RD_REQ) || (state == RD_WAIT);

  // A load arriving in the same IDLE cycle as a grant restarts that burst at 0.
  assign wr_ofs_cur = wr_load ? '0 : wr_ofs;
  assign rd_ofs_cur = rd_load ? '0 : rd_ofs;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n      = state;
    last_grant_n = last_grant;
    wr_ofs_n     = wr_ofs;
    rd_ofs_n     = rd_ofs;
    wr_pend_n    = wr_pend;
    rd_pend_n    = rd_pend;
    wr_req_n     = wr_req_q;
    rd_req_n     = rd_req_q;
    addr_n       = addr_q;
    fwd_n        = 1'b0;
    frd_n        = 1'b0;

    if (wr_load) begin
      if (wr_active) wr_pend_n = 1'b1;
      else           wr_ofs_n  = '0;
    end
    if (rd_load) begin
      if (rd_active) rd_pend_n = 1'b1;
      else           rd_ofs_n  = '0;
    end

    unique case (state)
      IDLE: begin
        if (pick_rd) begin
          state_n      = RD_REQ;
          rd_req_n     = 1'b1;
          addr_n       = {rd_bank, rd_ofs_cur};
          last_grant_n = GNT_RD;
        end else if (pick_wr) begin
          state_n      = WR_REQ;
          wr_req_n     = 1'b1;
          addr_n       = {wr_bank, wr_ofs_cur};
          last_grant_n = GNT_WR;
        end
      end
      WR_REQ: if (ctrl.burst_ack) begin
        wr_req_n = 1'b0;
        state_n  = WR_WAIT;
      end
      RD_REQ: if (ctrl.burst_ack) begin
        rd_req_n = 1'b0;
        state_n  = RD_WAIT;
      end
      WR_WAIT: if (ctrl.burst_done) begin
        state_n   = IDLE;
        fwd_n     = (wr_ofs == OFS_LAST);
        wr_pend_n = 1'b0;
        if (wr_pend || wr_load || wr_ofs == OFS_LAST) wr_ofs_n = '0;
        else                                          wr_ofs_n = wr_ofs + OFS_STEP;
      end
      RD_WAIT: if (ctrl.burst_done) begin
        state_n   = IDLE;
        frd_n     = (rd_ofs == OFS_LAST);
        rd_pend_n = 1'b0;
        if (rd_pend || rd_load || rd_ofs == OFS_LAST) rd_ofs_n = '0;
        else                                          rd_ofs_n = rd_ofs + OFS_STEP;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      last_grant       <= GNT_RD;
      wr_ofs           <= '0;
      rd_ofs           <= '0;
      wr_pend          <= 1'b0;
      rd_pend          <= 1'b0;
      wr_req_q         <= 1'b0;
      rd_req_q         <= 1'b0;
      addr_q           <= '0;
      frame_write_done <= 1'b0;
      frame_read_done  <= 1'b0;
    end else begin
      state            <= state_n;
      last_grant       <= last_grant_n;
      wr_ofs           <= wr_ofs_n;
      rd_ofs           <= rd_ofs_n;
      wr_pend          <= wr_pend_n;
      rd_pend          <= rd_pend_n;
      wr_req_q         <= wr_req_n;
      rd_req_q         <= rd_req_n;
      addr_q           <= addr_n;
      frame_write_done <= fwd_n;
      frame_read_done  <= frd_n;
    end
  end

  assign ctrl.sdram_wr_req = wr_req_q;
  assign ctrl.sdram_rd_req = rd_req_q;
  assign ctrl.sdram_addr   = addr_q;

endmodule
